// File: rtl/spi_tx_phy.sv
// Mode-0 SPI master PHY: shifts one 8- or 32-bit word out MSB-first on SCLK/MOSI
// while capturing MISO on each rising SCLK edge; CS is latched for the whole transfer.
module spi_tx_phy #(
  parameter int CLK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] spi_mosi,
  input  logic        spi_begin,
  input  logic        spi_wide,
  input  logic        spi_cs,
  output logic        spi_busy,
  output logic [31:0] spi_miso,
  output logic        phy_sclk,
  output logic        phy_mosi,
  input  logic        phy_miso,
  output logic        phy_cs
);

  typedef enum logic [1:0] {IDLE, LO, HI} state_t;

  localparam logic [7:0] DIV_LD = 8'(CLK_DIV - 1);

  state_t      state;
  logic        arm;
  logic        wide;
  logic [31:0] shift;
  logic [31:0] rx;
  logic [4:0]  bit_cnt;
  logic [7:0]  div_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      arm      <= 1'b1;
      wide     <= 1'b0;
      shift    <= '0;
      rx       <= '0;
      bit_cnt  <= '0;
      div_cnt  <= '0;
      spi_busy <= 1'b0;
      spi_miso <= '0;
      phy_sclk <= 1'b0;
      phy_mosi <= 1'b0;
      phy_cs   <= 1'b1;
    end else begin
      // A begin held high across completion must drop once before re-arming.
      if (!spi_begin) arm <= 1'b1;
      case (state)
        IDLE: begin
          phy_cs <= spi_cs;
          if (spi_begin && arm) begin
            arm      <= 1'b0;
            wide     <= spi_wide;
            shift    <= spi_wide ? spi_mosi : {spi_mosi[7:0], 24'h0};
            bit_cnt  <= spi_wide ? 5'd31 : 5'd7;
            div_cnt  <= DIV_LD;
            phy_mosi <= spi_wide ? spi_mosi[31] : spi_mosi[7];
            phy_sclk <= 1'b0;
            spi_busy <= 1'b1;
            state    <= LO;
          end
        end
        LO: begin
          if (div_cnt == 8'd0) begin
            phy_sclk <= 1'b1;
            rx       <= {rx[30:0], phy_miso};
            div_cnt  <= DIV_LD;
            state    <= HI;
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
        HI: begin
          if (div_cnt == 8'd0) begin
            phy_sclk <= 1'b0;
            if (bit_cnt == 5'd0) begin
              spi_miso <= wide ? rx : {24'h0, rx[7:0]};
              spi_busy <= 1'b0;
              state    <= IDLE;
            end else begin
              bit_cnt  <= bit_cnt - 5'd1;
              shift    <= {shift[30:0], 1'b0};
              phy_mosi <= shift[30];
              div_cnt  <= DIV_LD;
              state    <= LO;
            end
          end else begin
            div_cnt <= div_cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_tx_phy.sv
// Bench for spi_tx_phy: two instances (CLK_DIV 1 and 3) share the request bus; a
// pin-level monitor rebuilds the serial word, edge counts and phase lengths per instance.
module tb_spi_tx_phy;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] spi_mosi = '0;
  logic        spi_begin = 1'b0;
  logic        spi_wide = 1'b0;
  logic        spi_cs = 1'b1;
  logic        loop = 1'b1;
  logic [31:0] slave_word = '0;

  logic [1:0]  busy, sclk, pmosi, pmiso, pcs;
  logic [31:0] miso [2];

  int checks = 0;
  int errors = 0;

  int rises [2], tot_rises [2], starts [2], busy_run [2], last_busy [2];
  int phase_run [2], phase_err [2];
  logic [31:0] cap [2];
  logic [1:0] prev_busy = '0, prev_sclk = '0;

  always #5 clk = ~clk;

  spi_tx_phy #(.CLK_DIV(1)) u0 (
    .clk(clk), .rst_n(rst_n), .spi_mosi(spi_mosi), .spi_begin(spi_begin),
    .spi_wide(spi_wide), .spi_cs(spi_cs), .spi_busy(busy[0]), .spi_miso(miso[0]),
    .phy_sclk(sclk[0]), .phy_mosi(pmosi[0]), .phy_miso(pmiso[0]), .phy_cs(pcs[0]));

  spi_tx_phy #(.CLK_DIV(3)) u1 (
    .clk(clk), .rst_n(rst_n), .spi_mosi(spi_mosi), .spi_begin(spi_begin),
    .spi_wide(spi_wide), .spi_cs(spi_cs), .spi_busy(busy[1]), .spi_miso(miso[1]),
    .phy_sclk(sclk[1]), .phy_mosi(pmosi[1]), .phy_miso(pmiso[1]), .phy_cs(pcs[1]));

  function automatic int div_of(input int i);
    return (i == 1) ? 3 : 1;
  endfunction

  // Slave model: presents bit N-1-k of slave_word before the k-th rising SCLK.
  always_comb begin
    pmiso = '0;
    for (int i = 0; i < 2; i++) begin
      int idx;
      idx = (spi_wide ? 31 : 7) - rises[i];
      if (idx < 0) idx = 0;
      pmiso[i] = loop ? pmosi[i] : slave_word[idx];
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (busy[i] && !prev_busy[i]) begin
        starts[i]++;
        rises[i] = 0;
        cap[i] = '0;
        busy_run[i] = 1;
        phase_run[i] = 1;
      end else if (busy[i]) begin
        busy_run[i]++;
        if (sclk[i] != prev_sclk[i]) begin
          if (phase_run[i] != div_of(i)) phase_err[i]++;
          phase_run[i] = 1;
        end else begin
          phase_run[i]++;
        end
      end else if (prev_busy[i]) begin
        last_busy[i] = busy_run[i];
        if (phase_run[i] != div_of(i)) phase_err[i]++;
      end
      if (sclk[i] && !prev_sclk[i]) begin
        rises[i]++;
        tot_rises[i]++;
        cap[i] = {cap[i][30:0], pmosi[i]};
      end
      prev_busy[i] = busy[i];
      prev_sclk[i] = sclk[i];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_lvl(input int i, input logic lvl, input int max, input string tag);
    int n;
    n = 0;
    while (busy[i] !== lvl && n < max) begin
      tick();
      n++;
    end
    chk(tag, 32'(busy[i]), 32'(lvl));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy != 2'b00 && n < 500) begin
      tick();
      n++;
    end
    chk("idle", 32'(busy), 32'h0);
  endtask

  task automatic run_xfer(input int i, input logic [31:0] d, input logic w, input logic c,
                          input string tag);
    logic [31:0] src, exp;
    int nb;
    nb = w ? 32 : 8;
    spi_mosi = d;
    spi_wide = w;
    spi_cs = c;
    spi_begin = 1'b1;
    wait_lvl(i, 1'b1, 10, {tag, "_start"});
    tick();
    tick();
    spi_begin = 1'b0;
    wait_lvl(i, 1'b0, 400, {tag, "_end"});
    src = loop ? d : slave_word;
    exp = w ? src : {24'h0, src[7:0]};
    chk({tag, "_miso"}, miso[i], exp);
    chk({tag, "_mosi_bits"}, cap[i], w ? d : {24'h0, d[7:0]});
    chk({tag, "_rises"}, 32'(rises[i]), 32'(nb));
    chk({tag, "_busy_len"}, 32'(last_busy[i]), 32'(2 * div_of(i) * nb));
  endtask

  initial begin
    int s0, r0, n;
    logic [31:0] d;

    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_miso", miso[0], 32'h0);
    chk("rst_sclk", 32'(sclk), 32'h0);
    chk("rst_mosi", 32'(pmosi), 32'h0);
    chk("rst_cs", 32'(pcs), 32'h3);
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_busy", 32'(busy), 32'h0);

    // Narrow loopback at the fastest divider.
    loop = 1'b1;
    phase_err[0] = 0;
    run_xfer(0, 32'h123456A5, 1'b0, 1'b0, "narrow");
    chk("narrow_phase", 32'(phase_err[0]), 32'h0);

    // Wide loopback on the slow instance.
    wait_idle();
    phase_err[1] = 0;
    run_xfer(1, 32'hDEADBEEF, 1'b1, 1'b0, "wide");
    chk("wide_phase", 32'(phase_err[1]), 32'h0);

    // Begin held high through completion must not relaunch.
    wait_idle();
    s0 = starts[0];
    spi_mosi = $urandom;
    spi_wide = 1'b0;
    spi_begin = 1'b1;
    wait_lvl(0, 1'b1, 10, "held_start");
    wait_lvl(0, 1'b0, 100, "held_end");
    repeat (20) tick();
    chk("held_once", 32'(starts[0] - s0), 32'h1);
    chk("held_idle", 32'(busy[0]), 32'h0);
    spi_begin = 1'b0;
    tick();
    spi_begin = 1'b1;
    wait_lvl(0, 1'b1, 10, "held_restart");
    chk("held_twice", 32'(starts[0] - s0), 32'h2);
    spi_begin = 1'b0;
    wait_lvl(0, 1'b0, 100, "held_restart_end");

    // Controller-style handshake with a random slave word each time.
    loop = 1'b0;
    s0 = starts[0];
    r0 = tot_rises[0];
    for (int k = 0; k < 50; k++) begin
      slave_word = $urandom;
      d = $urandom;
      run_xfer(0, d, 1'b0, 1'b0, "hs");
    end
    chk("hs_count", 32'(starts[0] - s0), 32'd50);
    chk("hs_total_rises", 32'(tot_rises[0] - r0), 32'd400);

    // CS latched for the whole transfer, released one cycle into IDLE.
    wait_idle();
    loop = 1'b1;
    spi_mosi = $urandom;
    spi_wide = 1'b0;
    spi_cs = 1'b0;
    spi_begin = 1'b1;
    wait_lvl(0, 1'b1, 10, "cs_start");
    chk("cs_busy", 32'(pcs[0]), 32'h0);
    tick();
    tick();
    spi_begin = 1'b0;
    spi_cs = 1'b1;
    tick();
    chk("cs_mid", 32'(pcs[0]), 32'h0);
    wait_lvl(0, 1'b0, 100, "cs_end");
    chk("cs_at_fall", 32'(pcs[0]), 32'h0);
    tick();
    chk("cs_idle", 32'(pcs[0]), 32'h1);

    // Asynchronous reset in the middle of a wide transfer.
    wait_idle();
    spi_mosi = $urandom;
    spi_wide = 1'b1;
    spi_cs = 1'b0;
    spi_begin = 1'b1;
    wait_lvl(1, 1'b1, 10, "mid_start");
    n = 0;
    while (rises[1] < 13 && n < 400) begin
      tick();
      n++;
    end
    chk("mid_reached_bit13", 32'(rises[1]), 32'd13);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", 32'(busy[1]), 32'h0);
    chk("mid_sclk", 32'(sclk[1]), 32'h0);
    chk("mid_cs", 32'(pcs[1]), 32'h1);
    chk("mid_miso", miso[1], 32'h0);
    spi_begin = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    d = $urandom;
    run_xfer(1, d, 1'b1, 1'b0, "post_mid");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
